// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the 7-segment scan capture logic:
//   - SEG_BLANK: active-low pattern with every segment dark.
//   - scan_state_e: state encoding of the capture FSM.
//   - SEG7_CODES: active-low segment table for hex 0-F, seg[6:0] = g,f,e,d,c,b,a.
//   - seg7_decode / seg7_encode: both directions read the same table, so the
//     encoder in Main and this decoder cannot drift apart.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG7_CODES [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Returns {hit, nibble}; hit = 0 means the pattern is not a hex glyph.
    function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
        logic [4:0] result;
        result = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG7_CODES[i]) begin
                result = {1'b1, 4'(i)};
            end
        end
        return result;
    endfunction

    function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
        return SEG7_CODES[nibble];
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// seg_stable_filter
//   Registers the raw seg/an bus once and counts how many consecutive samples
//   have been identical. 'stable' is a combinational strobe that is high on the
//   single edge where the count reaches STABLE_CYC; the count then saturates so
//   the strobe cannot fire again until the bus changes.
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   seg, an         raw bus inputs (active-low)
//   s_seg, s_an     registered samples
//   changed         incoming sample differs from the registered one
//   stable          this edge brings the count to STABLE_CYC
module seg_stable_filter #(
    parameter int STABLE_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output logic [6:0] s_seg,
    output logic [3:0] s_an,
    output logic       changed,
    output logic       stable
);

    localparam int CW = $clog2(STABLE_CYC + 1);

    logic [6:0]    s_seg_q, s_seg_d;
    logic [3:0]    s_an_q, s_an_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s_seg_d = seg;
        s_an_d  = an;
        changed = (seg != s_seg_q) || (an != s_an_q);
        if (changed) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CW'(STABLE_CYC)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        stable = !changed && (cnt_q == CW'(STABLE_CYC - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_seg_q <= 7'h00;
            s_an_q  <= 4'h0;
            cnt_q   <= '0;
        end else begin
            s_seg_q <= s_seg_d;
            s_an_q  <= s_an_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_seg = s_seg_q;
    assign s_an  = s_an_q;

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Rebuilds the four hex digits shown on a multiplexed active-low 7-segment
//   bus. Each digit is accepted once per dwell after STABLE_CYC identical
//   samples; a frame is reported when all four positions have been accepted.
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   seg[6:0]        segment lines g..a, active-low
//   an[3:0]         anode enables, active-low, an[0] = rightmost digit
//   digits[15:0]    last accepted code per position {an3,an2,an1,an0}
//   digit_valid     position holds a decoded hex value
//   frame[15:0]     digits snapshot taken at frame_done
//   frame_done      one-cycle pulse when all four positions were accepted
//   err_pattern     sticky: stable non-blank pattern not in the table
//   err_multi_an    sticky: stable anode bus with more than one bit low
//   stale           no accept for TIMEOUT_CYC cycles
module seg_scan_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [15:0] frame,
    output logic        frame_done,
    output logic        err_pattern,
    output logic        err_multi_an,
    output logic        stale
);

    localparam int SW = $clog2(TIMEOUT_CYC + 1);

    logic [6:0] s_seg;
    logic [3:0] s_an;
    logic       changed, stable;

    seg_stable_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
        .clk     (clk),
        .reset   (reset),
        .seg     (seg),
        .an      (an),
        .s_seg   (s_seg),
        .s_an    (s_an),
        .changed (changed),
        .stable  (stable)
    );

    scan_state_e   state_q, state_d;
    logic [15:0]   digits_q, digits_d;
    logic [3:0]    valid_q, valid_d;
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   frame_q, frame_d;
    logic          frame_done_q, frame_done_d;
    logic          err_pattern_q, err_pattern_d;
    logic          err_multi_q, err_multi_d;
    logic [SW-1:0] stale_cnt_q, stale_cnt_d;
    logic          stale_q, stale_d;
    logic          accept;
    logic [1:0]    an_idx;
    logic [4:0]    decoded;

    // The FSM follows the sample being registered on this edge, so the accept
    // lands on the same edge the filter count reaches STABLE_CYC. Leaving IDLE
    // does not require a change, which covers the all-zero sample right after
    // reset.
    always_comb begin
        state_d       = state_q;
        digits_d      = digits_q;
        valid_d       = valid_q;
        seen_d        = seen_q;
        frame_d       = frame_q;
        frame_done_d  = 1'b0;
        err_pattern_d = err_pattern_q;
        err_multi_d   = err_multi_q;
        stale_cnt_d   = stale_cnt_q;
        decoded       = seg7_decode(s_seg);
        accept        = stable && (an != 4'hF) && (state_q != ST_HELD);

        case (s_an)
            4'b1101: an_idx = 2'd1;
            4'b1011: an_idx = 2'd2;
            4'b0111: an_idx = 2'd3;
            default: an_idx = 2'd0;
        endcase

        if (an == 4'hF) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            state_d = ST_HELD;
        end else if (changed || state_q == ST_IDLE) begin
            state_d = ST_SETTLE;
        end

        if (accept) begin
            if (!$onehot(~s_an)) begin
                err_multi_d = 1'b1;
            end else if (s_seg == SEG_BLANK) begin
                valid_d[an_idx] = 1'b0;
                seen_d[an_idx]  = 1'b1;
            end else if (decoded[4]) begin
                digits_d[{an_idx, 2'b00} +: 4] = decoded[3:0];
                valid_d[an_idx] = 1'b1;
                seen_d[an_idx]  = 1'b1;
            end else begin
                err_pattern_d = 1'b1;
            end
            // The snapshot includes the digit written on this same edge.
            if (seen_d == 4'hF) begin
                frame_d      = digits_d;
                frame_done_d = 1'b1;
                seen_d       = 4'h0;
            end
        end

        if (accept) begin
            stale_cnt_d = '0;
        end else if (stale_cnt_q != SW'(TIMEOUT_CYC)) begin
            stale_cnt_d = stale_cnt_q + SW'(1);
        end
        stale_d = (stale_cnt_d == SW'(TIMEOUT_CYC));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            digits_q      <= 16'h0;
            valid_q       <= 4'h0;
            seen_q        <= 4'h0;
            frame_q       <= 16'h0;
            frame_done_q  <= 1'b0;
            err_pattern_q <= 1'b0;
            err_multi_q   <= 1'b0;
            stale_cnt_q   <= '0;
            stale_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            digits_q      <= digits_d;
            valid_q       <= valid_d;
            seen_q        <= seen_d;
            frame_q       <= frame_d;
            frame_done_q  <= frame_done_d;
            err_pattern_q <= err_pattern_d;
            err_multi_q   <= err_multi_d;
            stale_cnt_q   <= stale_cnt_d;
            stale_q       <= stale_d;
        end
    end

    assign digits       = digits_q;
    assign digit_valid  = valid_q;
    assign frame        = frame_q;
    assign frame_done   = frame_done_q;
    assign err_pattern  = err_pattern_q;
    assign err_multi_an = err_multi_q;
    assign stale        = stale_q;

endmodule
